// File: rtl/spi_arb_pkg.sv
// Shared types for the SPI slave arbiter: FSM state encoding.
package spi_arb_pkg;

   localparam logic [1:0] ENC_IDLE   = 2'b00;
   localparam logic [1:0] ENC_GRANT  = 2'b01;
   localparam logic [1:0] ENC_ACTIVE = 2'b10;
   localparam logic [1:0] ENC_GAP    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = ENC_IDLE,
      ST_GRANT  = ENC_GRANT,
      ST_ACTIVE = ENC_ACTIVE,
      ST_GAP    = ENC_GAP
   } arb_state_t;

endpackage

// File: rtl/spi_rr_picker.sv
// Round-robin winner search: first set request after 'last', wrapping, with 'last' itself checked last.
module spi_rr_picker #(
   parameter int N = 3,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   output logic [W-1:0] winner,
   output logic         valid
);

   int idx;

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = 0;
      for (int i = 1; i <= N; i++) begin
         idx = int'(last) + i;
         if (idx >= N) idx = idx - N;
         if (!valid && req[W'(idx)]) begin
            valid  = 1'b1;
            winner = W'(idx);
         end
      end
   end

endmodule

// File: rtl/spi_slave_arbiter.sv
// Arbitrates N slave channels onto one shared SPI byte engine with grant timeout and inter-frame gap.
// Optional build macro SPI_ARB_PRIO0_EN: request 0 always wins arbitration when set.
//
// state  | meaning
// IDLE   | no grant; arbitrate any pending request
// GRANT  | grant issued, waiting for n_cs low (timeout counter running)
// ACTIVE | frame in progress, grant held until n_cs returns high
// GAP    | guard time with no grant before returning to IDLE
module spi_slave_arbiter
   import spi_arb_pkg::*;
#(
   parameter int N_SLAVES       = 3,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 255,
   localparam int SEL_W         = $clog2(N_SLAVES)
) (
   input  logic                n_rst,
   input  logic                sys_clk,
   input  logic [N_SLAVES-1:0] req_bus,
   input  logic                n_cs,
   output logic [N_SLAVES-1:0] grant_bus,
   output logic [SEL_W-1:0]    select,
   output logic                busy,
   output logic                timeout_pulse,
   output logic [SEL_W-1:0]    timeout_id
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] GAP_LEN     = CNT_W'((GAP_CYCLES < 1) ? 1 : GAP_CYCLES);

   arb_state_t            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
   logic [N_SLAVES-1:0]   grant_q, grant_d;
   logic [SEL_W-1:0]      select_q, select_d;
   logic                  tpulse_q, tpulse_d;
   logic [SEL_W-1:0]      tid_q, tid_d;
   logic                  busy_q;

   logic [SEL_W-1:0]      pick_idx, win_idx;
   logic                  pick_valid;

   spi_rr_picker #(.N(N_SLAVES)) u_picker (
      .req    (req_bus),
      .last   (select_q),
      .winner (pick_idx),
      .valid  (pick_valid)
   );

`ifdef SPI_ARB_PRIO0_EN
   assign win_idx = req_bus[0] ? '0 : pick_idx;
`else
   assign win_idx = pick_idx;
`endif

   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      grant_d  = grant_q;
      select_d = select_q;
      tpulse_d = 1'b0;
      tid_d    = tid_q;
      case (state_q)
         ST_IDLE: begin
            grant_d = '0;
            cnt_d   = '0;
            if (pick_valid) begin
               state_d  = ST_GRANT;
               select_d = win_idx;
               grant_d  = N_SLAVES'(1) << win_idx;
            end
         end
         ST_GRANT: begin
            // a frame start beats both a dropped request and a simultaneous timeout
            if (!n_cs) begin
               state_d = ST_ACTIVE;
               cnt_d   = '0;
            end else if (!req_bus[select_q]) begin
               state_d = ST_IDLE;
               grant_d = '0;
               cnt_d   = '0;
            end else if (cnt_inc == TIMEOUT_VAL) begin
               state_d  = ST_GAP;
               grant_d  = '0;
               cnt_d    = '0;
               tpulse_d = 1'b1;
               tid_d    = select_q;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_ACTIVE: begin
            if (n_cs) begin
               state_d = ST_GAP;
               grant_d = '0;
               cnt_d   = '0;
            end
         end
         ST_GAP: begin
            grant_d = '0;
            if (cnt_inc >= GAP_LEN) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!n_rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         grant_q  <= '0;
         select_q <= '0;
         tpulse_q <= 1'b0;
         tid_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         grant_q  <= grant_d;
         select_q <= select_d;
         tpulse_q <= tpulse_d;
         tid_q    <= tid_d;
         busy_q   <= (state_d != ST_IDLE);
      end
   end

   assign grant_bus     = grant_q;
   assign select        = select_q;
   assign busy          = busy_q;
   assign timeout_pulse = tpulse_q;
   assign timeout_id    = tid_q;

endmodule

// File: doc/spi_slave_arbiter.md
SPI_SLAVE_ARBITER -- requirements
Module: spi_slave_arbiter

Interface
REQ-001 Parameter N_SLAVES, default 3: number of requesters (slave channels); legal range 2..16.
REQ-002 Parameter GAP_CYCLES, default 4: idle guard cycles between frames; legal range 0..TIMEOUT_CYCLES.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: maximum cycles a grant may wait for frame start; legal range 1..65535.
REQ-004 Clock and reset: one clock; reset is synchronous and active-low.
- n_rst  in  1: synchronous active-low reset.
- sys_clk  in  1: sole clock; all state updates on its rising edge.
REQ-005 Requester and engine ports:
- req_bus  in  N_SLAVES: per-slave frame pending, level.
- n_cs  in  1: chip-select of the shared SPI byte engine; low means frame in progress.
- grant_bus  out  N_SLAVES: one-hot-or-zero grant.
- select  out  $clog2(N_SLAVES): index of the current or last granted slave.
- busy  out  1: state is not IDLE.
- timeout_pulse  out  1: one-cycle strobe on grant timeout.
- timeout_id  out  $clog2(N_SLAVES): slave that timed out; valid with timeout_pulse.

Function
REQ-006 The FSM SHALL have states IDLE, GRANT, ACTIVE and GAP.
REQ-007 IDLE: grant_bus=0; if any req_bus bit is set at edge t, the winner is registered into select and grant_bus, and the state is GRANT from t+1.
REQ-008 Winner: first set req_bus bit searching from select+1 upward, wrapping N_SLAVES-1 -> 0; select itself is searched last.
REQ-009 GRANT: wait counter starts at 0 and increments each cycle; n_cs sampled low -> ACTIVE.
REQ-010 GRANT, granted req bit deasserts before n_cs low: grant_bus cleared next cycle, state IDLE, no timeout.
REQ-011 GRANT, counter reaches TIMEOUT_CYCLES with n_cs high: timeout_pulse=1 and timeout_id=select for one cycle, grant_bus cleared, state GAP.
REQ-012 n_cs low in the same cycle that the timeout is reached: n_cs wins, state ACTIVE, no timeout_pulse.
REQ-013 ACTIVE: grant_bus and select held regardless of req_bus; n_cs sampled high -> grant_bus cleared, state GAP.
REQ-014 GAP: lasts max(GAP_CYCLES,1) cycles with grant_bus=0 and select stable, then IDLE.
REQ-015 select SHALL change only on the IDLE->GRANT transition.
REQ-016 grant_bus SHALL never have more than one bit set.
REQ-017 n_cs low while in IDLE or GAP is ignored; no state change.
REQ-018 All outputs SHALL be registered; the counter width is $clog2(TIMEOUT_CYCLES+1) and the counter saturates.

Reset
REQ-019 n_rst low at a clock edge: state IDLE, grant_bus=0, select=0, busy=0, timeout_pulse=0, timeout_id=0, counter=0, regardless of current state, including mid-frame.
REQ-020 After reset, the first arbitration searches from index 1.

Configuration
REQ-021 Macro SPI_ARB_PRIO0_EN defined: in IDLE, a set req_bus[0] wins unconditionally; all other requests use round-robin per REQ-008.
REQ-022 Macro SPI_ARB_PRIO0_EN undefined: pure round-robin; slave 0 has no precedence.

Structure
REQ-023 Package spi_arb_pkg SHALL hold the state enum and the encoding localparams.
REQ-024 Winner search SHALL be a sub-module spi_rr_picker with inputs req and last index and outputs winner index and valid.

Verification
REQ-025 N=3, req_bus=3'b111 held, each frame n_cs low for 16 cycles, GAP=4: grant order 1,2,0,1; gap 4 cycles between frames.
REQ-026 req_bus=3'b010, n_cs held high, TIMEOUT=255: timeout_pulse exactly 255 cycles after grant, timeout_id=1, state GAP then IDLE.
REQ-027 req_bus[2] dropped in GRANT before n_cs low: grant cleared next cycle, no timeout_pulse, busy=0.
REQ-028 SPI_ARB_PRIO0_EN defined, req_bus=3'b111 continuously: slave 0 granted every frame; without the macro: order 1,2,0.
REQ-029 n_rst asserted low in ACTIVE mid-frame: next cycle grant_bus=0, select=0, busy=0; first grant after release goes to slave 1 when req_bus=3'b111.
REQ-030 n_cs falls exactly at counter=TIMEOUT_CYCLES: state ACTIVE, no timeout_pulse.
